// File: rtl/imm_extend_unit_pkg.sv
// Shared definitions for the immediate-extension stage: extension mode
// encodings and the occupancy encodings of the two-entry output buffer.
package imm_extend_unit_pkg;

  typedef logic [1:0] imm_mode_t;

  localparam imm_mode_t IMM_SEXT  = 2'b00;
  localparam imm_mode_t IMM_ZEXT  = 2'b01;
  localparam imm_mode_t IMM_UPPER = 2'b10;
  localparam imm_mode_t IMM_SHAMT = 2'b11;

  // Buffer occupancy doubles as the state encoding of the handshake FSM.
  localparam logic [1:0] CNT_EMPTY = 2'd0;
  localparam logic [1:0] CNT_ONE   = 2'd1;
  localparam logic [1:0] CNT_TWO   = 2'd2;

endpackage : imm_extend_unit_pkg

// File: rtl/imm_extend_unit_core.sv
// Combinational immediate extender: widens an IN_W-bit field to OUT_W bits
// according to the selected extension mode.
module imm_extend_core
  import imm_extend_unit_pkg::*;
#(
  parameter int IN_W    = 16,
  parameter int OUT_W   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic [IN_W-1:0]  imm_i,
  input  logic [1:0]       mode_i,
  output logic [OUT_W-1:0] imm_o
);

  // Mode-driven extension; SHAMT looks only at the low SHAMT_W bits.
  always_comb begin
    // NOTE: a default assignment ahead of the case keeps every path driven, so no latch is inferred.
    imm_o = '0;
    case (mode_i)
      IMM_SEXT:  imm_o = {{(OUT_W-IN_W){imm_i[IN_W-1]}}, imm_i};
      IMM_ZEXT:  imm_o = {{(OUT_W-IN_W){1'b0}}, imm_i};
      IMM_UPPER: imm_o = {imm_i, {(OUT_W-IN_W){1'b0}}};
      IMM_SHAMT: imm_o = {{(OUT_W-SHAMT_W){imm_i[SHAMT_W-1]}}, imm_i[SHAMT_W-1:0]};
      default:   imm_o = '0;
    endcase
  end

endmodule : imm_extend_core

// File: rtl/imm_extend_unit.sv
// Registered immediate-extension stage with a two-entry skid buffer,
// valid/ready handshakes on both sides, a sideband tag and a flush.
module imm_extend_unit
  import imm_extend_unit_pkg::*;
#(
  parameter int IN_W    = 16,
  parameter int OUT_W   = 32,
  parameter int SHAMT_W = 5,
  parameter int TAG_W   = 5
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Flush,
  input  logic             InValid,
  output logic             InReady,
  input  logic [IN_W-1:0]  InImm,
  input  logic [1:0]       InMode,
  input  logic [TAG_W-1:0] InTag,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [OUT_W-1:0] OutImm,
  output logic [TAG_W-1:0] OutTag,
  output logic [1:0]       Count
);

  if (OUT_W <= IN_W || SHAMT_W > IN_W) begin : g_bad_params
    $fatal(1, "imm_extend_unit: need OUT_W > IN_W and SHAMT_W <= IN_W");
  end

  logic [OUT_W-1:0] ext_imm;

  imm_extend_core #(
    .IN_W    (IN_W),
    .OUT_W   (OUT_W),
    .SHAMT_W (SHAMT_W)
  ) u_core (
    .imm_i  (InImm),
    .mode_i (InMode),
    .imm_o  (ext_imm)
  );

  // Entry 0 is always the head; entry 1 is only meaningful when two are held.
  logic [1:0]       count_q, count_d;
  logic [OUT_W-1:0] imm0_q, imm0_d, imm1_q, imm1_d;
  logic [TAG_W-1:0] tag0_q, tag0_d, tag1_q, tag1_d;
  logic             push, pop;

  assign InReady  = (count_q != CNT_TWO);
  assign OutValid = (count_q != CNT_EMPTY);
  assign push     = InValid & InReady;
  assign pop      = OutValid & OutReady;

  // Next-state for occupancy and entry payloads; flush wins over push/pop.
  always_comb begin
    count_d = count_q;
    imm0_d  = imm0_q;
    tag0_d  = tag0_q;
    imm1_d  = imm1_q;
    tag1_d  = tag1_q;
    if (Flush) begin
      count_d = CNT_EMPTY;
    end else if (push && pop) begin
      // Only reachable with one entry held: the new beat replaces the head.
      imm0_d = ext_imm;
      tag0_d = InTag;
    end else if (push) begin
      if (count_q == CNT_EMPTY) begin
        imm0_d = ext_imm;
        tag0_d = InTag;
      end else begin
        imm1_d = ext_imm;
        tag1_d = InTag;
      end
      count_d = count_q + 2'd1;
    end else if (pop) begin
      imm0_d  = imm1_q;
      tag0_d  = tag1_q;
      count_d = count_q - 2'd1;
    end
  end

  // Occupancy register with synchronous reset.
  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    if (Reset) count_q <= CNT_EMPTY;
    else       count_q <= count_d;
  end

  // Payload storage.
  always_ff @(posedge Clk) begin
    // NOTE: payload entries are not reset; outputs are gated by occupancy, so stale data is never visible.
    imm0_q <= imm0_d;
    tag0_q <= tag0_d;
    imm1_q <= imm1_d;
    tag1_q <= tag1_d;
  end

  assign OutImm = OutValid ? imm0_q : '0;
  assign OutTag = OutValid ? tag0_q : '0;
  assign Count  = count_q;

endmodule : imm_extend_unit

// File: tb/tb_imm_extend_unit.sv
// Self-checking bench for imm_extend_unit using a scoreboard queue.
module tb_imm_extend_unit;
  import imm_extend_unit_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset, Flush, InValid, OutReady;
  logic        InReady, OutValid;
  logic [15:0] InImm;
  logic [1:0]  InMode;
  logic [4:0]  InTag;
  logic [31:0] OutImm;
  logic [4:0]  OutTag;
  logic [1:0]  Count;

  logic [31:0] in_exp;  // expected extension of the beat currently driven
  logic        mon_en = 1'b0;
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;

  typedef struct packed {
    logic [31:0] imm;
    logic [4:0]  tag;
  } sb_t;
  sb_t sb[$];

  imm_extend_unit dut (
    .Clk(Clk), .Reset(Reset), .Flush(Flush),
    .InValid(InValid), .InReady(InReady), .InImm(InImm), .InMode(InMode), .InTag(InTag),
    .OutValid(OutValid), .OutReady(OutReady), .OutImm(OutImm), .OutTag(OutTag),
    .Count(Count)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc++;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [15:0] imm, input logic [1:0] mode);
    logic [4:0] s;
    s = imm[4:0];
    case (mode)
      IMM_SEXT:  return 32'($signed(imm));
      IMM_ZEXT:  return {16'h0000, imm};
      IMM_UPPER: return {imm, 16'h0000};
      default:   return 32'($signed(s));
    endcase
  endfunction

  // Scoreboard monitor, sampled mid-cycle away from the active edge.
  always @(negedge Clk) begin
    if (mon_en) begin
      check("count", 32'(Count), 32'(sb.size()));
      check("in_ready", 32'(InReady), 32'(sb.size() != 2));
      check("out_valid", 32'(OutValid), 32'(sb.size() != 0));
      if (sb.size() == 0) begin
        check("idle_imm", OutImm, 32'h0);
        check("idle_tag", 32'(OutTag), 32'h0);
      end
      if (Reset || Flush) begin
        sb.delete();
      end else begin
        if (OutValid && OutReady && sb.size() != 0) begin
          sb_t e;
          e = sb.pop_front();
          check("out_imm", OutImm, e.imm);
          check("out_tag", 32'(OutTag), 32'(e.tag));
        end
        if (InValid && InReady) sb.push_back('{imm: in_exp, tag: InTag});
      end
    end
  end

  // Present one beat and hold it until accepted; returns 1 ns after the accepting edge.
  task automatic drive_beat(input logic [15:0] imm, input logic [1:0] mode,
                            input logic [4:0] tag, input logic [31:0] exp);
    bit acc = 1'b0;
    InValid = 1'b1; InImm = imm; InMode = mode; InTag = tag; in_exp = exp;
    for (int i = 0; i < 50; i++) begin
      @(negedge Clk);
      if (InReady) begin acc = 1'b1; break; end
    end
    if (!acc) check("accept_timeout", 32'(acc), 32'd1);
    @(posedge Clk); #1;
    InValid = 1'b0;
  endtask

  // Single beat into an empty unit: it must be at the outputs right after acceptance.
  task automatic single(input logic [15:0] imm, input logic [1:0] mode,
                        input logic [4:0] tag, input logic [31:0] exp);
    drive_beat(imm, mode, tag, exp);
    check("lat_valid", 32'(OutValid), 32'd1);
    check("lat_imm", OutImm, exp);
    check("lat_tag", 32'(OutTag), 32'(tag));
    @(posedge Clk); #1;
  endtask

  task automatic drain();
    OutReady = 1'b1;
    for (int i = 0; i < 100 && sb.size() != 0; i++) begin
      @(posedge Clk); #1;
    end
    check("drain", 32'(sb.size()), 32'd0);
    @(posedge Clk); #1;
  endtask

  initial begin
    int t0;
    Reset = 1'b1; Flush = 1'b0; InValid = 1'b0; OutReady = 1'b1;
    InImm = '0; InMode = IMM_SEXT; InTag = '0; in_exp = '0;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
    check("rst_count", 32'(Count), 32'd0);
    check("rst_in_ready", 32'(InReady), 32'd1);
    check("rst_out_valid", 32'(OutValid), 32'd0);
    check("rst_out_imm", OutImm, 32'h0);
    mon_en = 1'b1;

    // 1: sign and zero extension
    single(16'h8000, IMM_SEXT, 5'd4, 32'hFFFF8000);
    single(16'h7FFF, IMM_SEXT, 5'd5, 32'h00007FFF);
    single(16'h8000, IMM_ZEXT, 5'd6, 32'h00008000);

    // 2: upper and shift-amount forms
    single(16'h1234, IMM_UPPER, 5'd7, 32'h12340000);
    single(16'h0013, IMM_SHAMT, 5'd8, 32'hFFFFFFF3);
    single(16'hFF0A, IMM_SHAMT, 5'd9, 32'h0000000A);

    // 3: back-pressure with a held third beat
    OutReady = 1'b0;
    drive_beat(16'h0101, IMM_ZEXT, 5'd1, 32'h00000101);
    drive_beat(16'hF102, IMM_SEXT, 5'd2, 32'hFFFFF102);
    InValid = 1'b1; InImm = 16'h0003; InMode = IMM_UPPER; InTag = 5'd3; in_exp = 32'h00030000;
    @(negedge Clk);
    check("t3_count_full", 32'(Count), 32'd2);
    check("t3_in_ready_low", 32'(InReady), 32'd0);
    @(posedge Clk); #1;
    OutReady = 1'b1;
    drive_beat(16'h0003, IMM_UPPER, 5'd3, 32'h00030000);
    drain();

    // 4: simultaneous push and pop at one entry replaces the head
    OutReady = 1'b0;
    drive_beat(16'h00AA, IMM_ZEXT, 5'd10, 32'h000000AA);
    OutReady = 1'b1;
    InValid = 1'b1; InImm = 16'h8BBB; InMode = IMM_SEXT; InTag = 5'd11; in_exp = 32'hFFFF8BBB;
    @(posedge Clk); #1;
    InValid = 1'b0; OutReady = 1'b0;
    check("t4_count", 32'(Count), 32'd1);
    check("t4_head_tag", 32'(OutTag), 32'd11);
    check("t4_head_imm", OutImm, 32'hFFFF8BBB);
    drain();

    // 4b: streaming eight beats at full rate
    OutReady = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 8; i++) begin
      logic [15:0] v;
      logic [1:0]  m;
      v = 16'($urandom);
      m = 2'(i);
      drive_beat(v, m, 5'(12 + i), model(v, m));
    end
    check("t4_stream_cycles", 32'(cyc - t0), 32'd8);
    drain();

    // 5: flush with a full buffer and a beat on the input
    OutReady = 1'b0;
    drive_beat(16'h1111, IMM_ZEXT, 5'd21, 32'h00001111);
    drive_beat(16'h2222, IMM_ZEXT, 5'd22, 32'h00002222);
    Flush = 1'b1; OutReady = 1'b1;
    InValid = 1'b1; InImm = 16'h3333; InMode = IMM_ZEXT; InTag = 5'd23; in_exp = 32'h00003333;
    @(posedge Clk); #1;
    Flush = 1'b0; InValid = 1'b0;
    check("t5_count", 32'(Count), 32'd0);
    check("t5_out_valid", 32'(OutValid), 32'd0);
    check("t5_in_ready", 32'(InReady), 32'd1);
    repeat (3) @(posedge Clk);
    #1;

    // 6: reset mid-stream, then normal operation
    OutReady = 1'b0;
    drive_beat(16'h4444, IMM_UPPER, 5'd24, 32'h44440000);
    drive_beat(16'h5555, IMM_UPPER, 5'd25, 32'h55550000);
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    check("t6_count", 32'(Count), 32'd0);
    check("t6_out_valid", 32'(OutValid), 32'd0);
    check("t6_in_ready", 32'(InReady), 32'd1);
    check("t6_out_imm", OutImm, 32'h0);
    check("t6_out_tag", 32'(OutTag), 32'h0);
    OutReady = 1'b1;
    single(16'h0016, IMM_SHAMT, 5'd26, 32'hFFFFFFF6);
    drain();

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_imm_extend_unit
